// File: rtl/psg_pan_mixer.sv
// Serial stereo mixer for NCH unsigned PSG channels: one channel accumulated per clock
// after each accepted ce_sample, then shifted and saturated to OUT_W-bit L/R samples.
module psg_pan_mixer #(
  parameter int NCH        = 3,
  parameter int WIDTH      = 12,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 3,
  parameter int MONO_SHIFT = 2
) (
  input  logic                 clk_sys_i,
  input  logic                 reset_i,
  input  logic                 ce_sample_i,
  input  logic [NCH*WIDTH-1:0] ch_in_i,
  input  logic [1:0]           mode_i,
  input  logic [2*NCH-1:0]     pan_i,
  output logic [OUT_W-1:0]     audio_l_o,
  output logic [OUT_W-1:0]     audio_r_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic [7:0]           overrun_o
);

  localparam int ACC_W  = WIDTH + $clog2(NCH) + 1;
  localparam int IDX_W  = $clog2(NCH);
  localparam int MAXS   = (SHIFT > MONO_SHIFT) ? SHIFT : MONO_SHIFT;
  localparam int FULL_W = (ACC_W + MAXS > OUT_W) ? ACC_W + MAXS : OUT_W + 1;
  localparam logic [FULL_W-1:0] SAT_MAX = (FULL_W'(1) << OUT_W) - FULL_W'(1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t               state_q;
  logic [NCH*WIDTH-1:0] ch_q;
  logic [1:0]           mode_q;
  logic [2*NCH-1:0]     pan_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ACC_W-1:0]     acc_l_q, acc_r_q, acc_l_d, acc_r_d;
  logic [OUT_W-1:0]     audio_l_q, audio_r_q;
  logic                 valid_q, busy_q;
  logic [7:0]           overrun_q;
  logic [WIDTH-1:0]     ch_cur;
  logic                 w_l, w_r, mono;

  // Shift at full width so saturation sees every bit before truncation.
  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] a, input logic is_mono);
    logic [FULL_W-1:0] s;
    s = is_mono ? (FULL_W'(a) << MONO_SHIFT) : (FULL_W'(a) << SHIFT);
    return (s > SAT_MAX) ? {OUT_W{1'b1}} : s[OUT_W-1:0];
  endfunction

  assign mono = (mode_q == 2'd0);

  // Mono mode uses acc_l as the single accumulator.
  always_comb begin
    ch_cur = '0;
    w_l    = 1'b0;
    w_r    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ch_cur = ch_q[i*WIDTH +: WIDTH];
        case (mode_q)
          2'd0:    begin w_l = 1'b1;     w_r = 1'b0;     end
          2'd1:    begin w_l = (i != 2); w_r = (i != 0); end
          2'd2:    begin w_l = (i != 1); w_r = (i != 0); end
          default: {w_r, w_l} = pan_q[2*i +: 2];
        endcase
      end
    end
  end

  assign acc_l_d = acc_l_q + (w_l ? ACC_W'(ch_cur) : ACC_W'(0));
  assign acc_r_d = acc_r_q + (w_r ? ACC_W'(ch_cur) : ACC_W'(0));

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      mode_q    <= '0;
      pan_q     <= '0;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (ce_sample_i) begin
          ch_q    <= ch_in_i;
          mode_q  <= mode_i;
          pan_q   <= pan_i;
          acc_l_q <= '0;
          acc_r_q <= '0;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ACC;
        end
        ACC: begin
          acc_l_q <= acc_l_d;
          acc_r_q <= acc_r_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NCH - 1)) begin
            audio_l_q <= sat(acc_l_d, mono);
            audio_r_q <= mono ? sat(acc_l_d, 1'b1) : sat(acc_r_d, 1'b0);
            valid_q   <= 1'b1;
            state_q   <= OUT;
          end
        end
        OUT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Strobes during ACC or OUT (the valid cycle) are dropped and counted.
      if (state_q != IDLE && ce_sample_i && overrun_q != 8'hFF)
        overrun_q <= overrun_q + 8'd1;
    end
  end

  assign audio_l_o = audio_l_q;
  assign audio_r_o = audio_r_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_psg_pan_mixer.sv
// Directed bench for psg_pan_mixer: expected samples queued at each accepted strobe,
// popped and compared by a monitor whenever valid pulses.
module tb_psg_pan_mixer;
  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [35:0] ch_in;
  logic [1:0]  mode;
  logic [5:0]  pan;
  logic [15:0] audio_l, audio_r;
  logic        valid, busy;
  logic [7:0]  overrun;

  psg_pan_mixer dut (
    .clk_sys_i(clk), .reset_i(reset), .ce_sample_i(ce), .ch_in_i(ch_in),
    .mode_i(mode), .pan_i(pan), .audio_l_o(audio_l), .audio_r_o(audio_r),
    .valid_o(valid), .busy_o(busy), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int l; int r; int due; } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference mix straight from the weight table.
  function automatic void model(input int c0, c1, c2, input int md, input logic [5:0] pn,
                                output int l, output int r);
    int ch[3];
    int sl, sr;
    logic wl, wr;
    ch = '{c0, c1, c2};
    sl = 0; sr = 0;
    for (int i = 0; i < 3; i++) begin
      case (md)
        0:       begin wl = 1'b1;     wr = 1'b0;     end
        1:       begin wl = (i != 2); wr = (i != 0); end
        2:       begin wl = (i != 1); wr = (i != 0); end
        default: begin wl = pn[2*i]; wr = pn[2*i+1]; end
      endcase
      if (wl) sl += ch[i];
      if (wr) sr += ch[i];
    end
    if (md == 0) begin
      l = sl << 2; r = l;
    end else begin
      l = sl << 3; r = sr << 3;
    end
    if (l > 65535) l = 65535;
    if (r > 65535) r = 65535;
  endfunction

  // Strobe once with the DUT idle; the strobe is accepted on the next edge.
  task automatic mix(input int c0, c1, c2, input int md, input logic [5:0] pn);
    exp_t e;
    ch_in = {12'(c2), 12'(c1), 12'(c0)};
    mode  = 2'(md);
    pan   = pn;
    model(c0, c1, c2, md, pn, e.l, e.r);
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    e.due = cyc + NCH;
    q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((q.size() != 0 || busy) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      n_vec++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_valid: observed valid=1 expected no pending mix");
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("audio_l", audio_l, e.l);
        chk("audio_r", audio_r, e.r);
        chk("latency", cyc, e.due);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops, next_ok, c0, c1, c2, md;
    exp_t e;
    reset = 1'b1; ce = 1'b0; ch_in = '0; mode = '0; pan = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_l", audio_l, 0);
    chk("rst_r", audio_r, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic modes
    mix(100, 200, 300, 1, 6'b0);
    chk("busy_in_acc", busy, 1);
    drain("abc");
    mix(100, 200, 300, 2, 6'b0);         drain("acb");
    mix(100, 200, 300, 0, 6'b0);         drain("mono");
    mix(4095, 4095, 4095, 0, 6'b0);      drain("mono_full");
    mix(4095, 4095, 4095, 3, 6'b111111); drain("custom_sat");
    mix(4095, 4095, 4095, 1, 6'b0);      drain("abc_full");
    mix(4095, 4095, 4095, 2, 6'b0);      drain("acb_full");

    // Inputs changed mid-mix must not affect the running mix
    mix(1000, 1000, 1000, 3, 6'b00_10_01);
    pan = 6'b111111; mode = 2'd0; ch_in = {3{12'd7}};
    drain("pan_shadow");
    mix(1000, 1000, 1000, 3, 6'b111111); drain("pan_new");

    for (int k = 0; k < 6; k++) begin
      c0 = $urandom_range(0, 4095); c1 = $urandom_range(0, 4095);
      c2 = $urandom_range(0, 4095); md = $urandom_range(0, 3);
      mix(c0, c1, c2, md, 6'($urandom_range(0, 63)));
      drain("random");
    end
    chk("ovr_zero", overrun, 0);

    // Strobe every 2 cycles: accept only once the previous mix has finished
    ch_in = {12'd300, 12'd200, 12'd100}; mode = 2'd1; pan = '0;
    model(100, 200, 300, 1, 6'b0, e.l, e.r);
    drops = 0; next_ok = 0;
    for (int k = 0; k < 20; k++) begin
      ce = 1'b1;
      @(posedge clk); #1;
      ce = 1'b0;
      if (cyc >= next_ok) begin
        e.due = cyc + NCH; q.push_back(e); next_ok = cyc + NCH + 2;
      end else drops++;
      @(posedge clk); #1;
    end
    drain("strobe2");
    chk("ovr_count", overrun, drops);

    // Continuous strobe long enough for >255 drops
    ce = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (cyc >= next_ok) begin
        e.due = cyc + NCH; q.push_back(e); next_ok = cyc + NCH + 2;
      end else drops++;
    end
    ce = 1'b0;
    drain("strobe_cont");
    chk("ovr_sat", overrun, (drops > 255) ? 255 : drops);

    // Reset during ACC aborts the mix
    mix(500, 600, 700, 1, 6'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_l", audio_l, 0);
    chk("abort_r", audio_r, 0);
    chk("abort_ovr", overrun, 0);
    mix(100, 200, 300, 2, 6'b0);
    drain("after_reset");
    repeat (5) @(posedge clk);
    #1;
    chk("idle_end", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
